core_seq_ctrl: RTL
==================

CORE_SEQ_CTRL -- requirements
Module: core_seq_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 255: maximum wait cycles in IF_WAIT, MDU or MEM_WAIT before ERR; 0 disables the watchdog.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide port if_req_valid  output  1  instruction-fetch request.
REQ-005 SHALL provide port if_req_ready  input  1  fetch request accepted.
REQ-006 SHALL provide port if_rsp_valid  input  1  fetched instruction is valid.
REQ-007 SHALL provide ports dec_is_load, dec_is_store, dec_is_mdu, dec_is_ebreak, dec_wen  input  1 each  decoder class flags and register-write enable.
REQ-008 SHALL provide port mdu_start  output  1  one-cycle start pulse to the mul/div unit.
REQ-009 SHALL provide port mdu_done  input  1  mul/div result is ready.
REQ-010 SHALL provide ports mem_req_valid  output  1, mem_req_ready  input  1, mem_rsp_valid  input  1  data-memory handshake.
REQ-011 SHALL provide ports ir_we, pc_we, rf_we  output  1 each  instruction-register, PC and register-file write strobes.
REQ-012 SHALL provide ports halt, err  output  1 each  sticky halt and sticky error flags.
REQ-013 SHALL provide port state  output  4  current state encoding.
REQ-014 SHALL provide ports cyc_cnt, instret_cnt  output  64 each  performance counters.

Function
REQ-015 SHALL use state encodings FETCH=0, IF_WAIT=1, EXEC=2, MDU=3, MEM=4, MEM_WAIT=5, WB=6, HALT=7, ERR=8.
REQ-016 FETCH SHALL hold if_req_valid=1 and go to IF_WAIT on if_req_ready=1; if_rsp_valid SHALL be ignored in FETCH.
REQ-017 IF_WAIT SHALL pulse ir_we for one cycle and go to EXEC on if_rsp_valid=1.
REQ-018 EXEC SHALL last exactly one cycle and branch by priority: dec_is_ebreak -> HALT; dec_is_mdu -> MDU with mdu_start=1 in the EXEC cycle; dec_is_load or dec_is_store -> MEM; otherwise -> WB.
REQ-019 When dec_is_load and dec_is_store are both 1, the block SHALL take the MEM path once.
REQ-020 MDU SHALL go to WB on mdu_done=1; mdu_done seen in any other state SHALL be ignored.
REQ-021 MEM SHALL hold mem_req_valid=1 until mem_req_ready=1, then go to MEM_WAIT; MEM_WAIT SHALL go to WB on mem_rsp_valid=1; stores SHALL also wait for the response.
REQ-022 WB SHALL last one cycle with pc_we=1 and rf_we=dec_wen, then go to FETCH.
REQ-023 ALU-class latency with zero-wait memory SHALL be 4 cycles per instruction (FETCH, IF_WAIT, EXEC, WB).
REQ-024 The watchdog counter SHALL clear on entry to each wait state and increment each cycle in IF_WAIT, MDU or MEM_WAIT; when it reaches TIMEOUT with TIMEOUT!=0, the block SHALL go to ERR.
REQ-025 HALT and ERR SHALL be terminal until reset, with halt=1 or err=1 respectively and all request and strobe outputs 0.
REQ-026 All request and strobe outputs SHALL be Moore/combinational functions of state and the REQ-016..022 inputs, with no extra register stage.

Reset
REQ-027 rst=1 SHALL immediately force state=FETCH, clear the watchdog and counters, and set halt=0 and err=0; it SHALL abort any in-flight transaction without completing its WB.
REQ-028 During reset, every output SHALL be 0 except if_req_valid, which SHALL be 1 from the first clock edge after rst deasserts.

Configuration
REQ-029 With SEQ_PERF_CNT_EN defined, cyc_cnt SHALL increment every cycle outside HALT/ERR, and instret_cnt SHALL increment on each pc_we; both SHALL wrap modulo 2^64.
REQ-030 Without SEQ_PERF_CNT_EN, cyc_cnt and instret_cnt SHALL be constant 0, no counter flops SHALL be synthesized, and the ports SHALL remain present.

Structure
REQ-031 State encodings and the state width SHALL be defined in shared package core_seq_pkg, for reuse by the debug/trace logic.
REQ-032 The counters SHALL be implemented in one sub-module, seq_perf_cnt, instantiated only under SEQ_PERF_CNT_EN.

Verification
REQ-033 ALU instruction, ready/rsp tied high: states 0,1,2,6,0; ir_we in cycle 1; pc_we=1 and rf_we=1 in cycle 3; instret_cnt=1.
REQ-034 Load with mem_req_ready delayed 2 cycles and rsp 3 cycles later: state 4 held 3 cycles, 5 held 3 cycles, then 6; pc_we pulses once.
REQ-035 dec_is_mdu with mdu_done after 10 cycles: mdu_start pulses once in EXEC, MDU held 10 cycles, then WB.
REQ-036 TIMEOUT=4 and if_rsp_valid never asserted: ERR entered after 4 IF_WAIT cycles; err=1 sticky; cyc_cnt frozen.
REQ-037 ebreak: state 7, halt=1, no pc_we; rst pulse mid-MEM_WAIT returns to FETCH with all counters 0.

Source files
------------

// File: rtl/core_seq_pkg.sv
// Shared encodings for the instruction sequencer and its debug/trace consumers.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package core_seq_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH    = 4'd0,
    ST_IF_WAIT  = 4'd1,
    ST_EXEC     = 4'd2,
    ST_MDU      = 4'd3,
    ST_MEM      = 4'd4,
    ST_MEM_WAIT = 4'd5,
    ST_WB       = 4'd6,
    ST_HALT     = 4'd7,
    ST_ERR      = 4'd8
  } seq_state_t;

  // States in which the sequencer waits on an external responder and the watchdog runs.
  function automatic logic is_wait_state(input seq_state_t s);
    return (s == ST_IF_WAIT) || (s == ST_MDU) || (s == ST_MEM_WAIT);
  endfunction

endpackage

// File: rtl/seq_perf_cnt.sv
// Cycle and retired-instruction counters, 64-bit, wrapping.
// Latency: a count event is visible on the outputs one clock after it occurs.
// Backpressure: none; counts whatever the sequencer reports each cycle.
`ifdef SEQ_PERF_CNT_EN
module seq_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_inc,
  input  logic        ret_inc,
  output logic [63:0] cyc_cnt,
  output logic [63:0] instret_cnt
);

  // Both counters roll over naturally at 2^64.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt     <= '0;
      instret_cnt <= '0;
    end else begin
      if (cyc_inc) cyc_cnt <= cyc_cnt + 64'd1;
      if (ret_inc) instret_cnt <= instret_cnt + 64'd1;
    end
  end

endmodule
`endif

// File: rtl/core_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch, execute, mul/div, data memory, writeback; optional counters via SEQ_PERF_CNT_EN.
// Latency: 4 cycles per ALU instruction with zero-wait fetch; waits extend IF_WAIT/MDU/MEM/MEM_WAIT.
// Backpressure: holds requests until ready; watchdog (TIMEOUT, 0 = off) sends a stuck wait to ERR.
module core_seq_ctrl
  import core_seq_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_req_valid,
  input  logic        if_req_ready,
  input  logic        if_rsp_valid,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_is_mdu,
  input  logic        dec_is_ebreak,
  input  logic        dec_wen,
  output logic        mdu_start,
  input  logic        mdu_done,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        halt,
  output logic        err,
  output logic [3:0]  state,
  output logic [63:0] cyc_cnt,
  output logic [63:0] instret_cnt
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  seq_state_t      state_q, state_d;
  logic [WD_W-1:0] wd_q;
  logic            started_q;
  logic            wd_expire;

  // Expires on the cycle whose increment would reach TIMEOUT, so a wait lasts exactly TIMEOUT cycles.
  assign wd_expire = (TIMEOUT != 0) && ((32'(wd_q) + 32'd1) == 32'(TIMEOUT));
  assign state     = state_q;

  // State, watchdog and start flag; started_q keeps the fetch request low until the first edge out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      started_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      // Every wait state is entered from a non-wait state, so zeroing outside them clears on entry.
      if (is_wait_state(state_q) && (state_d == state_q) && (TIMEOUT != 0))
        wd_q <= wd_q + WD_W'(1);
      else
        wd_q <= '0;
    end
  end

  // Next state and Moore/Mealy strobes.
  always_comb begin
    state_d       = state_q;
    if_req_valid  = 1'b0;
    ir_we         = 1'b0;
    mdu_start     = 1'b0;
    mem_req_valid = 1'b0;
    pc_we         = 1'b0;
    rf_we         = 1'b0;
    halt          = 1'b0;
    err           = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if_req_valid = started_q;
        if (started_q && if_req_ready) state_d = ST_IF_WAIT;
      end
      ST_IF_WAIT: begin
        if (if_rsp_valid) begin
          ir_we   = 1'b1;
          state_d = ST_EXEC;
        end else if (wd_expire) begin
          state_d = ST_ERR;
        end
      end
      ST_EXEC: begin
        if (dec_is_ebreak) begin
          state_d = ST_HALT;
        end else if (dec_is_mdu) begin
          mdu_start = 1'b1;
          state_d   = ST_MDU;
        end else if (dec_is_load || dec_is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MDU: begin
        if (mdu_done) state_d = ST_WB;
        else if (wd_expire) state_d = ST_ERR;
      end
      ST_MEM: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (mem_rsp_valid) state_d = ST_WB;
        else if (wd_expire) state_d = ST_ERR;
      end
      ST_WB: begin
        pc_we   = 1'b1;
        rf_we   = dec_wen;
        state_d = ST_FETCH;
      end
      ST_HALT: halt = 1'b1;
      ST_ERR:  err  = 1'b1;
      default: state_d = ST_ERR;
    endcase
  end

`ifdef SEQ_PERF_CNT_EN
  seq_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .cyc_inc     ((state_q != ST_HALT) && (state_q != ST_ERR)),
    .ret_inc     (pc_we),
    .cyc_cnt     (cyc_cnt),
    .instret_cnt (instret_cnt)
  );
`else
  assign cyc_cnt     = 64'd0;
  assign instret_cnt = 64'd0;
`endif

endmodule
